punc_mem_responder: RTL and testbench

Memory-side responder for the PUnC LC3 processor: the slave end of the control unit's memory access path. It accepts one read or write request at a time over a valid/ready handshake, services it against an internal word array after a fixed latency, and holds the response until the processor accepts it. Multi-access instructions (LDI, STI) are issued by the control unit as consecutive independent requests.

---
 rtl/punc_mem_responder_pkg.sv | 37 +++
 rtl/punc_mem_responder_if.sv | 44 ++++
 rtl/punc_mem_responder_array.sv | 59 +++++
 rtl/punc_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_punc_mem_responder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/punc_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// punc_mem_responder_pkg
//
// Shared definitions for the PUnC memory responder slice:
//   - default geometry (8-bit word address, 16-bit PUnC word)
//   - default access latency and the latency counter width
//   - one-hot responder state encoding (MEM_IDLE / MEM_WAIT / MEM_RESP)
//   - helper that computes the counter preload for a given latency
// -----------------------------------------------------------------------------
package punc_mem_responder_pkg;

  // Default geometry: 256 words of 16 bits (the PUnC LC3 word width).
  localparam int MEM_ADDR_W  = 8;
  localparam int MEM_DATA_W  = 16;

  // Default request-accept to response latency, in cycles (legal 1..15).
  localparam int MEM_LATENCY = 2;

  // Latency counter width; 4 bits covers the whole legal latency range.
  localparam int MEM_CNT_W   = 4;

  typedef logic [MEM_CNT_W-1:0] lat_cnt_t;

  // One-hot responder states.
  typedef enum logic [2:0] {
    MEM_IDLE = 3'b001,
    MEM_WAIT = 3'b010,
    MEM_RESP = 3'b100
  } mem_state_e;

  // The accept edge itself is the first latency cycle, so the counter is
  // loaded with one less than the requested latency.
  function automatic lat_cnt_t lat_load(input int latency);
    return lat_cnt_t'(latency - 1);
  endfunction

endpackage : punc_mem_responder_pkg

// File: rtl/punc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// punc_mem_responder_if
//
// Request/response channel between the PUnC control unit (master) and the
// memory responder (slave).
//
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_we     master->slave  1 = write, 0 = read
//   req_addr   master->slave  word address (ADDR_W)
//   req_wdata  master->slave  write data (DATA_W)
//   resp_valid slave->master  response available
//   resp_ready master->slave  master accepts the response
//   resp_rdata slave->master  read data, or echo of the written word
// -----------------------------------------------------------------------------
interface punc_mem_responder_if
  import punc_mem_responder_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  // Control-unit side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  // Memory side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface : punc_mem_responder_if

// File: rtl/punc_mem_responder_array.sv
// -----------------------------------------------------------------------------
// punc_mem_array
//
// Single-port word array with a synchronous write, a registered access
// port and a combinational debug read port.
//
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (read register only)
//   en         in   perform an access this edge
//   we         in   1 = write wdata to addr, 0 = read addr
//   addr       in   word address
//   wdata      in   write data
//   rdata      out  registered result: array[addr] for reads, wdata for writes
//   dbg_addr   in   inspection address
//   dbg_rdata  out  combinational array[dbg_addr]
// -----------------------------------------------------------------------------
module punc_mem_array
  import punc_mem_responder_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage has no reset branch on purpose: contents must survive
  // rst, and a reset on a RAM array blocks inference of a memory macro.
  // NOTE: non-blocking assignments in clocked blocks so every register sees
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // A write echoes the written word rather than reading the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule : punc_mem_array

// File: rtl/punc_mem_responder.sv
// -----------------------------------------------------------------------------
// punc_mem_responder
//
// Slave end of the PUnC control unit's memory path. Accepts one read or
// write at a time, services it against an internal word array after a
// fixed LATENCY, and holds the response until the master takes it.
// LDI/STI arrive as independent consecutive requests; no pipelining.
//
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (array contents kept)
//   bus        slave modport of punc_mem_responder_if
//   busy       out  high while waiting or holding a response
//   dbg_addr   in   inspection address
//   dbg_rdata  out  combinational array[dbg_addr], no side effects
//
// Timing: a request seen in the cycle after edge t gives resp_valid from
// edge t+LATENCY; the array access (write commit or read capture) happens on
// the same edge that enters RESP.
// -----------------------------------------------------------------------------
module punc_mem_responder
  import punc_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  punc_mem_responder_if.slave    bus,
  output logic                   busy,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_rdata
);

  mem_state_e        state_q;
  mem_state_e        state_d;
  lat_cnt_t          cnt_q;

  // Request captured at accept, used when the access happens later.
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = (state_q == MEM_IDLE) && bus.req_valid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latency counter and request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= lat_load(LATENCY);
    end else if ((state_q == MEM_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - lat_cnt_t'(1);
    end
  end

  // Pure datapath: only consumed after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: begin
        if (bus.req_valid) begin
          state_d = (LATENCY == 1) ? MEM_RESP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // Counter reads 1 in the last waiting cycle; <= guards a stray 0.
        if (cnt_q <= lat_cnt_t'(1)) begin
          state_d = MEM_RESP;
        end
      end
      MEM_RESP: begin
        if (bus.resp_ready) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;  // recover from a corrupted one-hot code
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    busy           = 1'b0;
    case (state_q)
      MEM_IDLE: bus.req_ready  = 1'b1;
      MEM_WAIT: busy           = 1'b1;
      MEM_RESP: begin
        bus.resp_valid = 1'b1;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array access
  // ---------------------------------------------------------------------------
  // The access fires on the edge that enters RESP. With LATENCY=1 that is the
  // accept edge itself, so the live request is used instead of the capture.
  // rst suppresses the access, which discards a write still pending in WAIT.
  assign arr_en    = (state_q != MEM_RESP) && (state_d == MEM_RESP) && !rst;
  assign arr_we    = (state_q == MEM_IDLE) ? bus.req_we    : we_q;
  assign arr_addr  = (state_q == MEM_IDLE) ? bus.req_addr  : addr_q;
  assign arr_wdata = (state_q == MEM_IDLE) ? bus.req_wdata : wdata_q;

  punc_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .en        (arr_en),
    .we        (arr_we),
    .addr      (arr_addr),
    .wdata     (arr_wdata),
    .rdata     (arr_rdata),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  // Only updated on an access, so it holds steady through backpressure.
  assign bus.resp_rdata = arr_rdata;

endmodule : punc_mem_responder

// File: tb/tb_punc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_punc_mem_responder
//
// Directed bench for punc_mem_responder. Three instances share clk/rst:
// LATENCY=2 (main), LATENCY=1 and LATENCY=15. Inputs are driven and outputs
// sampled on the falling edge; every step() crosses exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_punc_mem_responder;

  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int LAT_M  = 2;
  localparam int LAT_1  = 1;
  localparam int LAT_15 = 15;

  logic          clk;
  logic          rst;
  logic          busy_m, busy_1, busy_15;
  logic [AW-1:0] dbg_addr_m, dbg_addr_1, dbg_addr_15;
  logic [DW-1:0] dbg_rdata_m, dbg_rdata_1, dbg_rdata_15;

  int n_cmp;
  int n_err;

  punc_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_m  ();
  punc_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_1  ();
  punc_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_15 ();

  punc_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_M)) dut (
    .clk(clk), .rst(rst), .bus(bus_m), .busy(busy_m),
    .dbg_addr(dbg_addr_m), .dbg_rdata(dbg_rdata_m)
  );

  punc_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_1)) dut_l1 (
    .clk(clk), .rst(rst), .bus(bus_1), .busy(busy_1),
    .dbg_addr(dbg_addr_1), .dbg_rdata(dbg_rdata_1)
  );

  punc_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_15)) dut_l15 (
    .clk(clk), .rst(rst), .bus(bus_15), .busy(busy_15),
    .dbg_addr(dbg_addr_15), .dbg_rdata(dbg_rdata_15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers. 'which' selects the instance: 0 = main, 1 = L1, 2 = L15.
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int lat_of(input int which);
    case (which)
      1:       return LAT_1;
      2:       return LAT_15;
      default: return LAT_M;
    endcase
  endfunction

  task automatic set_req(input int which, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    case (which)
      1: begin bus_1.req_valid = v;  bus_1.req_we = we;  bus_1.req_addr = a;  bus_1.req_wdata = d;  end
      2: begin bus_15.req_valid = v; bus_15.req_we = we; bus_15.req_addr = a; bus_15.req_wdata = d; end
      default: begin bus_m.req_valid = v; bus_m.req_we = we; bus_m.req_addr = a; bus_m.req_wdata = d; end
    endcase
  endtask

  task automatic set_rr(input int which, input logic v);
    case (which)
      1:       bus_1.resp_ready  = v;
      2:       bus_15.resp_ready = v;
      default: bus_m.resp_ready  = v;
    endcase
  endtask

  task automatic set_dbg(input int which, input logic [AW-1:0] a);
    case (which)
      1:       dbg_addr_1  = a;
      2:       dbg_addr_15 = a;
      default: dbg_addr_m  = a;
    endcase
  endtask

  function automatic logic get_rv(input int which);
    case (which)
      1:       return bus_1.resp_valid;
      2:       return bus_15.resp_valid;
      default: return bus_m.resp_valid;
    endcase
  endfunction

  function automatic logic get_rq(input int which);
    case (which)
      1:       return bus_1.req_ready;
      2:       return bus_15.req_ready;
      default: return bus_m.req_ready;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      1:       return busy_1;
      2:       return busy_15;
      default: return busy_m;
    endcase
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int which);
    case (which)
      1:       return bus_1.resp_rdata;
      2:       return bus_15.resp_rdata;
      default: return bus_m.resp_rdata;
    endcase
  endfunction

  function automatic logic [DW-1:0] get_dbg(input int which);
    case (which)
      1:       return dbg_rdata_1;
      2:       return dbg_rdata_15;
      default: return dbg_rdata_m;
    endcase
  endfunction

  // One complete transaction: present the request for one edge, count edges
  // until resp_valid, optionally hold the response off for 'hold' cycles while
  // offering a competing request, then complete the handshake.
  task automatic transact(input int which, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp,
                          input int hold, input string tag);
    int n;
    int bad_wait;
    n        = 0;
    bad_wait = 0;
    set_dbg(which, a);
    set_req(which, 1'b1, we, a, d);
    do begin
      step();
      n++;
      if (n == 1) set_req(which, 1'b0, 1'b0, '0, '0);
      if (!get_busy(which) || get_rq(which)) bad_wait++;
    end while (!get_rv(which) && n < 40);
    check({tag, "_latency"}, n, lat_of(which));
    check({tag, "_busy_wait"}, bad_wait, 0);
    check({tag, "_rdata"}, get_rdata(which), exp);
    if (we) check({tag, "_dbg"}, get_dbg(which), d);
    for (int i = 0; i < hold; i++) begin
      set_req(which, 1'b1, 1'b1, a ^ 8'hFF, 16'hDEAD);
      step();
      check({tag, "_hold_valid"}, get_rv(which), 1);
      check({tag, "_hold_rdata"}, get_rdata(which), exp);
      check({tag, "_hold_ready"}, get_rq(which), 0);
    end
    set_req(which, 1'b0, 1'b0, '0, '0);
    set_rr(which, 1'b1);
    step();
    set_rr(which, 1'b0);
    check({tag, "_done_ready"}, get_rq(which), 1);
    check({tag, "_done_valid"}, get_rv(which), 0);
    check({tag, "_done_busy"}, get_busy(which), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    dbg_addr_m = '0; dbg_addr_1 = '0; dbg_addr_15 = '0;
    for (int w = 0; w < 3; w++) begin
      set_req(w, 1'b1, 1'b1, 8'h66, 16'h6666);  // must lose to rst
      set_rr(w, 1'b1);
    end
    step();
    step();
    for (int w = 0; w < 3; w++) begin
      set_req(w, 1'b0, 1'b0, '0, '0);
      set_rr(w, 1'b0);
    end
    rst = 1'b0;
    step();

    // Reset state.
    check("rst_req_ready",  bus_m.req_ready,  1);
    check("rst_resp_valid", bus_m.resp_valid, 0);
    check("rst_resp_rdata", bus_m.resp_rdata, 16'h0000);
    check("rst_busy",       busy_m,           0);
    check("rst_l15_ready",  bus_15.req_ready, 1);

    // Write/readback, then read under 5 cycles of backpressure.
    transact(0, 1'b1, 8'h05, 16'h1234, 16'h1234, 0, "wr05");
    transact(0, 1'b0, 8'h05, 16'h0000, 16'h1234, 5, "rd05_bp");
    set_dbg(0, 8'h05 ^ 8'hFF);
    step();
    check("bp_ignored_write_ready", bus_m.req_ready, 1);
    transact(0, 1'b0, 8'h05, 16'h0000, 16'h1234, 0, "rd05_again");

    // LDI-style pointer chase: read 0x10 yields 0x0020, then read 0x20.
    transact(0, 1'b1, 8'h10, 16'h0020, 16'h0020, 0, "pre10");
    transact(0, 1'b1, 8'h20, 16'hBEEF, 16'hBEEF, 0, "pre20");
    transact(0, 1'b0, 8'h10, 16'h0000, 16'h0020, 0, "ldi_ptr");
    transact(0, 1'b0, 8'h20, 16'h0000, 16'hBEEF, 0, "ldi_data");

    // Reset during WAIT discards a pending write.
    transact(0, 1'b1, 8'h07, 16'h5555, 16'h5555, 0, "pre07");
    set_dbg(0, 8'h07);
    set_req(0, 1'b1, 1'b1, 8'h07, 16'hAAAA);
    step();
    check("rstw_in_wait", busy_m, 1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_mem",        dbg_rdata_m,     16'h5555);
    check("rstw_resp_valid", bus_m.resp_valid, 0);
    check("rstw_req_ready",  bus_m.req_ready,  1);
    step();
    step();
    check("rstw_mem_later",  dbg_rdata_m,     16'h5555);

    // Reset in RESP: write has committed, response is dropped.
    set_dbg(0, 8'h08);
    set_req(0, 1'b1, 1'b1, 8'h08, 16'h7777);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();
    check("rstr_in_resp", bus_m.resp_valid, 1);
    rst = 1'b1;
    set_rr(0, 1'b1);
    step();
    rst = 1'b0;
    set_rr(0, 1'b0);
    check("rstr_mem",        dbg_rdata_m,      16'h7777);
    check("rstr_resp_valid", bus_m.resp_valid, 0);
    check("rstr_resp_rdata", bus_m.resp_rdata, 16'h0000);

    // Back-to-back writes to one address with a read in between.
    transact(0, 1'b1, 8'h03, 16'h0001, 16'h0001, 0, "b2b_wr1");
    transact(0, 1'b0, 8'h03, 16'h0000, 16'h0001, 0, "b2b_rd");
    transact(0, 1'b1, 8'h03, 16'h0002, 16'h0002, 0, "b2b_wr2");
    set_dbg(0, 8'h03);
    step();
    check("b2b_final", dbg_rdata_m, 16'h0002);

    // LATENCY=1 instance, including a short backpressure hold.
    transact(1, 1'b1, 8'h33, 16'h00A1, 16'h00A1, 0, "l1_wr");
    transact(1, 1'b0, 8'h33, 16'h0000, 16'h00A1, 2, "l1_rd");

    // LATENCY=15 instance.
    transact(2, 1'b1, 8'h44, 16'h0F0F, 16'h0F0F, 0, "l15_wr");
    transact(2, 1'b0, 8'h44, 16'h0000, 16'h0F0F, 0, "l15_rd");

    // Main instance unaffected by the other builds.
    set_dbg(0, 8'h20);
    step();
    check("final_main_mem", dbg_rdata_m, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_punc_mem_responder
